// File: rtl/y_adder.sv
// 32-bit add/subtract through one shared ripple carry chain, with combinational
// results and a registered copy of the result and flags for the next pipeline stage.
module y_adder (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ctrl,
    output logic [31:0] z,
    output logic        cout,
    output logic        ovf,
    output logic        zero,
    output logic [31:0] z_q,
    output logic        cout_q,
    output logic        ovf_q,
    output logic        zero_q
);

    logic [31:0] bi;
    logic [31:0] sum;
    logic [32:0] c;

    // Subtract reuses the adder: invert b and inject the +1 as carry-in.
    always_comb begin
        bi   = b ^ {32{ctrl}};
        sum  = '0;
        c    = '0;
        c[0] = ctrl;
        for (int unsigned i = 0; i < 32; i++) begin
            sum[i]  = a[i] ^ bi[i] ^ c[i];
            c[i+1]  = (a[i] & bi[i]) | (c[i] & (a[i] ^ bi[i]));
        end
    end

    assign z    = sum;
    assign cout = c[32];
    assign ovf  = c[32] ^ c[31];
    assign zero = ~|sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            z_q    <= z;
            cout_q <= cout;
            ovf_q  <= ovf;
            zero_q <= zero;
        end
    end

endmodule

// File: tb/tb_y_adder.sv
// Bench for y_adder: directed literal cases, async reset behaviour, and a
// randomized regression checked every cycle against an arithmetic model.
module tb_y_adder;

    typedef struct packed {
        logic [31:0] z;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        ctrl = 1'b0;
    logic [31:0] z, z_q;
    logic        cout, ovf, zero, cout_q, ovf_q, zero_q;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;
    res_t exp_q = '0;

    y_adder dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .ctrl(ctrl),
        .z(z), .cout(cout), .ovf(ovf), .zero(zero),
        .z_q(z_q), .cout_q(cout_q), .ovf_q(ovf_q), .zero_q(zero_q)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned/signed arithmetic on wide integers.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        res_t   r;
        longint sr;
        if (s) begin
            r.z    = x - y;
            r.cout = (x >= y);
            sr     = longint'($signed(x)) - longint'($signed(y));
        end else begin
            {r.cout, r.z} = {1'b0, x} + {1'b0, y};
            sr     = longint'($signed(x)) + longint'($signed(y));
        end
        r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r.zero = (r.z == 32'd0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    // Expected registered values: cleared by reset, else the model of the inputs at the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_q = '0;
        else       exp_q = model(a, b, ctrl);
    end

    // Every cycle, 2 time units after inputs are applied.
    initial begin
        res_t m;
        forever begin
            @(posedge clk);
            #3;
            if (chk_on) begin
                m = model(a, b, ctrl);
                chk("z",      z,             m.z);
                chk("cout",   32'(cout),     32'(m.cout));
                chk("ovf",    32'(ovf),      32'(m.ovf));
                chk("zero",   32'(zero),     32'(m.zero));
                chk("z_q",    z_q,           exp_q.z);
                chk("cout_q", 32'(cout_q),   32'(exp_q.cout));
                chk("ovf_q",  32'(ovf_q),    32'(exp_q.ovf));
                chk("zero_q", 32'(zero_q),   32'(exp_q.zero));
            end
        end
    end

    task automatic apply(input logic [31:0] x, input logic [31:0] y, input logic s);
        @(posedge clk);
        #1;
        a = x; b = y; ctrl = s;
        vectors++;
        #2;
    endtask

    task automatic lit(input string name, input logic [31:0] ez, input logic ec,
                       input logic eo, input logic ezr);
        chk({name, ".z"},    z,          ez);
        chk({name, ".cout"}, 32'(cout),  32'(ec));
        chk({name, ".ovf"},  32'(ovf),   32'(eo));
        chk({name, ".zero"}, 32'(zero),  32'(ezr));
    endtask

    initial begin
        logic [31:0] x, y;
        // Reset held across edges: registered outputs stay 0, zero_q included.
        repeat (2) @(posedge clk);
        #3;
        chk("rst.z_q",    z_q,         32'd0);
        chk("rst.cout_q", 32'(cout_q), 32'd0);
        chk("rst.ovf_q",  32'(ovf_q),  32'd0);
        chk("rst.zero_q", 32'(zero_q), 32'd0);
        chk("rst.zero",   32'(zero),   32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_on = 1'b1;

        apply(32'd5, 32'd3, 1'b0);           lit("add5p3", 32'd8, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("add5p3.z_q", z_q, 32'd8);
        #1;
        apply(32'd5, 32'd3, 1'b1);           lit("sub5m3", 32'd2, 1'b1, 1'b0, 1'b0);
        apply(32'd3, 32'd5, 1'b1);           lit("sub3m5", 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        apply(32'h7FFFFFFF, 32'd1, 1'b0);    lit("addovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
        apply(32'hFFFFFFFF, 32'd1, 1'b0);    lit("addwrap", 32'd0, 1'b1, 1'b0, 1'b1);
        apply(32'h80000000, 32'd1, 1'b1);    lit("subovf", 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        apply(32'h12345678, 32'h12345678, 1'b1); lit("subeq", 32'd0, 1'b1, 1'b0, 1'b1);

        // Async reset between edges while registers hold a nonzero result.
        apply(32'h00001000, 32'h00000234, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst.z_q", z_q, 32'h00001234);
        #2 reset = 1'b1;
        #1;
        chk("arst.z_q",    z_q,         32'd0);
        chk("arst.cout_q", 32'(cout_q), 32'd0);
        chk("arst.ovf_q",  32'(ovf_q),  32'd0);
        chk("arst.zero_q", 32'(zero_q), 32'd0);
        chk("arst.z",      z,           32'h00001234);
        @(posedge clk); #1;
        chk("hold.z_q", z_q, 32'd0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("rel.z_q", z_q, 32'h00001234);

        // Random regression with a bias toward boundary operands.
        for (int i = 0; i < 1200; i++) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: x = 32'h80000000;
                1: y = 32'h7FFFFFFF;
                2: y = x;
                3: x = 32'hFFFFFFFF;
                default: ;
            endcase
            apply(x, y, 1'($urandom_range(0, 1)));
        end
        @(posedge clk); #4;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
